lc3b_fetch_unit: RTL
====================

# lc3b_fetch_unit

Decoupled LC-3b instruction fetch stage: owns the PC, issues word reads to instruction memory, and buffers returned instructions with their PCs in a parametrised-depth queue feeding decode through a valid/ready handshake. Branch/jump redirects from later stages flush the queue and restart fetch, discarding any in-flight response. It replaces the single-entry PC-plus-IF/ID arrangement so decode stalls no longer stall memory.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- RESET_PC, 16'h0000, PC loaded on reset

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- imem_read  out  1  read request; held high until imem_resp
- imem_address  out  16  word-aligned fetch address; stable while imem_read is high
- imem_resp  in  1  one-cycle pulse: imem_rdata valid
- imem_rdata  in  16  returned instruction
- redirect  in  1  flush and restart at redirect_pc
- redirect_pc  in  16  new PC; bit 0 ignored (forced 0)
- deq_valid  out  1  head entry valid
- deq_instr  out  16  head instruction
- deq_pc  out  16  head instruction address
- deq_ready  in  1  decode accepts head when deq_valid is high
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- FSM states: REQ (read outstanding), IDLE (queue full, no read), DROP (stale read outstanding, result discarded).
- REQ: imem_read=1, imem_address=pc. On imem_resp: enqueue {pc, rdata}; pc<=pc+2 (mod 2^16). Stay in REQ if an entry is still free after this cycle's enqueue and dequeue, otherwise go to IDLE.
- IDLE: imem_read=0; go to REQ when count<DEPTH (a dequeue in the same cycle counts).
- Dequeue happens when deq_valid && deq_ready. An enqueue and a dequeue in the same cycle leave count unchanged. An enqueue into a full queue is impossible by construction (assertion).
- redirect takes priority over everything in its cycle:
  - The queue is flushed (count=0 next cycle) and a dequeue that cycle is ignored.
  - pc<=redirect_pc.
  - In REQ with no imem_resp that cycle: go to DROP.
  - In REQ with imem_resp that cycle: the response is discarded; go to REQ.
  - In IDLE: go to REQ.
  - In DROP: stay in DROP with the new pc.
- DROP: imem_read=1 and imem_address holds the old address. On imem_resp, discard the data and go to REQ at pc.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - state=REQ, pc=RESET_PC, count=0, deq_valid=0.
  - deq_instr and deq_pc are 0.
  - imem_read=1 and imem_address=RESET_PC immediately after reset.
- Reset mid-request abandons the request; memory is required to tolerate this.
- Latency: imem_resp in cycle t gives deq_valid in t+1. There is no same-cycle bypass.
- The next request address is presented in t+1. Peak throughput is one instruction per cycle with a one-cycle memory.
- Redirect in cycle t gives count=0 in t+1. The first new request appears in t+1, unless the FSM enters DROP.
- deq_* are driven from queue storage (registered); deq_ready has no combinational path to imem_*.

## Configuration
- LC3B_FETCH_PREDECODE_EN defined:
  - Each entry stores an extra bit, set when opcode (instr[15:12]) is BR, JMP, JSR or TRAP.
  - The bit is presented on an added output, deq_ctrl_flow (1 bit, reset 0), aligned with deq_instr.
- Undefined: no deq_ctrl_flow port and no extra storage; behaviour is otherwise identical.

## Structure
- lc3b_types package holds:
  - lc3b_word
  - lc3b_opcode with named opcode constants (op_br, op_jmp, op_jsr, op_trap)
  - the fetch FSM state enum
- One sub-module, fetch_fifo:
  - parametrised in DEPTH and entry width
  - provides push/pop/flush, count, and head outputs
- The top level holds the PC, the FSM and predecode.

## Test plan
- Reset, then memory answers each read in one cycle, deq_ready=1 -> addresses 0000,0002,0004…; deq_pc matches each fetch address, and deq_valid stays 1 from the second response on.
- deq_ready=0, DEPTH=4 -> after 4 responses count=4, imem_read=0. One dequeue -> imem_read=1 next cycle, address 0008.
- redirect to 3001 while a read of 0004 is outstanding and unanswered -> address stays 0004 until imem_resp and that data is never dequeued; the next request is at 3000.
- redirect to 4000 in the same cycle as imem_resp and a dequeue -> count=0 next cycle, the response is dropped, and the next address is 4000.
- pc=FFFE, response accepted -> next address 0000, and deq_pc=FFFE for that entry.
- With LC3B_FETCH_PREDECODE_EN, fetch x0E02 (BR) then x1261 (ADD) -> deq_ctrl_flow is 1 then 0.

Source files
------------

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types, opcode constants and fetch FSM states
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;

    localparam lc3b_opcode op_br   = 4'b0000;
    localparam lc3b_opcode op_jsr  = 4'b0100;
    localparam lc3b_opcode op_jmp  = 4'b1100;
    localparam lc3b_opcode op_trap = 4'b1111;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t st_req  = 2'd0;
    localparam fetch_state_t st_idle = 2'd1;
    localparam fetch_state_t st_drop = 2'd2;

    // Instructions that may change the PC flow (used by predecode)
    function automatic logic is_ctrl_flow(input lc3b_word instr);
        lc3b_opcode op;
        op = instr[15:12];
        return (op == op_br) || (op == op_jmp) || (op == op_jsr) || (op == op_trap);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two circular queue with push/pop/flush and registered head
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push_eff;
    logic             pop_eff;

    // Flush wins over both push and pop in the same cycle
    assign push_eff   = push && !flush;
    assign pop_eff    = pop && head_valid && !flush;
    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_eff, pop_eff})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_eff) begin
            assert (count != CW'(DEPTH));
        end
    end

endmodule

// File: rtl/lc3b_fetch_unit.sv
// rtl/lc3b_fetch_unit.sv - decoupled LC-3b fetch stage (PC, fetch FSM, queue); LC3B_FETCH_PREDECODE_EN adds deq_ctrl_flow
module lc3b_fetch_unit
    import lc3b_types::*;
#(
    parameter int       DEPTH    = 4,
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_read,
    output logic [15:0]                imem_address,
    input  logic                       imem_resp,
    input  logic [15:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [15:0]                redirect_pc,
    output logic                       deq_valid,
    output logic [15:0]                deq_instr,
    output logic [15:0]                deq_pc,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef LC3B_FETCH_PREDECODE_EN
    ,
    output logic                       deq_ctrl_flow
`endif
);

    localparam int CW = $clog2(DEPTH+1);
`ifdef LC3B_FETCH_PREDECODE_EN
    localparam int EW = 33;
`else
    localparam int EW = 32;
`endif

    fetch_state_t   state;
    fetch_state_t   state_d;
    lc3b_word       pc;
    lc3b_word       drop_addr;
    logic           push;
    logic           pop;
    logic           has_room;
    logic [CW:0]    occ_next;
    logic [EW-1:0]  push_data;
    logic [EW-1:0]  head_data;

    assign push = (state == st_req) && imem_resp && !redirect;
    assign pop  = deq_valid && deq_ready && !redirect;

    // Occupancy after this cycle's enqueue/dequeue decides whether to keep fetching
    assign occ_next = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    assign has_room = occ_next < (CW+1)'(DEPTH);

`ifdef LC3B_FETCH_PREDECODE_EN
    assign push_data     = {is_ctrl_flow(imem_rdata), pc, imem_rdata};
    assign deq_ctrl_flow = head_data[32];
`else
    assign push_data = {pc, imem_rdata};
`endif
    assign deq_instr = head_data[15:0];
    assign deq_pc    = head_data[31:16];

    assign imem_read    = (state != st_idle);
    assign imem_address = (state == st_drop) ? drop_addr : pc;

    always_comb begin
        state_d = state;
        case (state)
            st_req: begin
                if (redirect) begin
                    state_d = imem_resp ? st_req : st_drop;
                end else if (imem_resp && !has_room) begin
                    state_d = st_idle;
                end
            end
            st_idle: begin
                if (redirect || has_room) begin
                    state_d = st_req;
                end
            end
            st_drop: begin
                if (!redirect && imem_resp) begin
                    state_d = st_req;
                end
            end
            default: state_d = st_req;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= st_req;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state <= state_d;
            if (redirect) begin
                pc <= {redirect_pc[15:1], 1'b0};
                // The abandoned read keeps its address on the bus until it completes
                if (state == st_req && !imem_resp) begin
                    drop_addr <= pc;
                end
            end else if (push) begin
                pc <= pc + 16'd2;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk        (clk),
        .rst        (reset),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .flush      (redirect),
        .head_valid (deq_valid),
        .head_data  (head_data),
        .count      (count)
    );

endmodule
